hazard_control_unit: RTL and testbench

//  Stall/flush side of RISC-V 5-stage hazard handling: covers the cases bypass cannot (load-use, data-memory wait, taken branch).

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_control_unit_sat_counter.sv | 33 +++
 rtl/hazard_control_unit.sv | 161 ++++++++++++++++
 tb/tb_hazard_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard control
//               unit: dmem wait FSM encoding, the x0 register index and a
//               source-operand match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Dmem wait FSM state encoding
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_e;

  // Architectural zero register; never a real dependency
  localparam logic [4:0] REG_X0 = 5'd0;

  // True when the ID instruction really reads 'src' and it equals 'rd'
  function automatic logic src_match(input logic       use_src,
                                     input logic [4:0] src,
                                     input logic [4:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. Holds at
//               all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  // Count up on inc, stick at all-ones, clear has priority
  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Stall/flush control for a 5-stage RISC-V pipeline. Handles
//               load-use stalls, data-memory wait freezes with timeout and
//               taken-branch flushes, plus stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_IDrs1,
  input  logic [4:0]       IF_IDrs2,
  input  logic             IF_IDuseRs1,
  input  logic             IF_IDuseRs2,
  input  logic [4:0]       ID_EXrd,
  input  logic             ID_EXmemRead,
  input  logic             EX_MEMmemRead,
  input  logic             EX_MEMmemWrite,
  input  logic             dmem_ready,
  input  logic             branchTaken,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             ID_EXWrite,
  output logic             EX_MEMWrite,
  output logic             IF_IDflush,
  output logic             ID_EXflush,
  output logic             MEM_WBflush,
  output logic             dmem_req,
  output logic             busError,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  // Wait counter only needs to reach TIMEOUT-1
  localparam int                  c_WCNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WCNT_W-1:0] c_WAIT_LAST = c_WCNT_W'(TIMEOUT - 1);
  localparam logic [c_WCNT_W-1:0] c_WAIT_ONE  = c_WCNT_W'(1);

  hz_state_e           r_state,     w_state_nxt;
  logic [c_WCNT_W-1:0] r_wait_cnt,  w_wait_cnt_nxt;
  logic                r_bus_error, w_bus_error_nxt;

  logic w_mem_op;
  logic w_freeze;
  logic w_load_use;
  logic w_branch_flush;

  assign w_mem_op   = EX_MEMmemRead | EX_MEMmemWrite;
  // Once a bus error is latched the memory is considered dead: stop waiting on it
  assign w_freeze   = w_mem_op & ~dmem_ready & ~r_bus_error;
  assign w_load_use = ID_EXmemRead && (ID_EXrd != REG_X0) &&
                      (src_match(IF_IDuseRs1, IF_IDrs1, ID_EXrd) ||
                       src_match(IF_IDuseRs2, IF_IDrs2, ID_EXrd));

  // Pipeline enable/flush decode; priority reset > freeze > branch > load-use
  always_comb begin
    PCWrite        = 1'b1;
    IF_IDWrite     = 1'b1;
    ID_EXWrite     = 1'b1;
    EX_MEMWrite    = 1'b1;
    IF_IDflush     = 1'b0;
    ID_EXflush     = 1'b0;
    MEM_WBflush    = 1'b0;
    dmem_req       = w_mem_op & ~r_bus_error;
    w_branch_flush = 1'b0;
    if (reset) begin
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      ID_EXWrite  = 1'b0;
      EX_MEMWrite = 1'b0;
      IF_IDflush  = 1'b1;
      ID_EXflush  = 1'b1;
      MEM_WBflush = 1'b1;
      dmem_req    = 1'b0;
    end else if (w_freeze) begin
      // Whole front of the pipe holds; MEM result is not valid yet
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      ID_EXWrite  = 1'b0;
      EX_MEMWrite = 1'b0;
      MEM_WBflush = 1'b1;
    end else if (branchTaken) begin
      // Dependent instruction in ID is squashed anyway, so no load-use stall
      IF_IDflush     = 1'b1;
      ID_EXflush     = 1'b1;
      w_branch_flush = 1'b1;
    end else if (w_load_use) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXflush = 1'b1;
    end
  end

  // Dmem wait FSM next-state and timeout detection
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_bus_error_nxt = r_bus_error;
    case (r_state)
      RUN: begin
        if (w_freeze) begin
          w_state_nxt    = WAIT;
          w_wait_cnt_nxt = c_WAIT_ONE;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_state_nxt     = RUN;
          w_wait_cnt_nxt  = '0;
          w_bus_error_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + c_WAIT_ONE;
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, wait counter and sticky bus error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_bus_error <= w_bus_error_nxt;
    end
  end

  assign busError = r_bus_error;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (~reset & ~PCWrite),
    .count (stallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (w_branch_flush),
    .count (flushCount)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Directed self-checking bench for hazard_control_unit. A
//               second instance with 4-bit counters shares the stimulus to
//               observe counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IF_IDrs1, IF_IDrs2, ID_EXrd;
  logic       IF_IDuseRs1, IF_IDuseRs2, ID_EXmemRead;
  logic       EX_MEMmemRead, EX_MEMmemWrite, dmem_ready, branchTaken;

  logic        PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite;
  logic        IF_IDflush, ID_EXflush, MEM_WBflush, dmem_req, busError;
  logic [31:0] stallCount, flushCount;

  logic        PCWrite_s, IF_IDWrite_s, ID_EXWrite_s, EX_MEMWrite_s;
  logic        IF_IDflush_s, ID_EXflush_s, MEM_WBflush_s, dmem_req_s, busError_s;
  logic [3:0]  stallCount_s, flushCount_s;

  // {PCWrite,IF_IDWrite,ID_EXWrite,EX_MEMWrite,IF_IDflush,ID_EXflush,MEM_WBflush,dmem_req}
  logic [7:0] ctl;
  assign ctl = {PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite,
                IF_IDflush, ID_EXflush, MEM_WBflush, dmem_req};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .IF_IDrs1(IF_IDrs1), .IF_IDrs2(IF_IDrs2),
    .IF_IDuseRs1(IF_IDuseRs1), .IF_IDuseRs2(IF_IDuseRs2),
    .ID_EXrd(ID_EXrd), .ID_EXmemRead(ID_EXmemRead),
    .EX_MEMmemRead(EX_MEMmemRead), .EX_MEMmemWrite(EX_MEMmemWrite),
    .dmem_ready(dmem_ready), .branchTaken(branchTaken),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .ID_EXWrite(ID_EXWrite),
    .EX_MEMWrite(EX_MEMWrite), .IF_IDflush(IF_IDflush), .ID_EXflush(ID_EXflush),
    .MEM_WBflush(MEM_WBflush), .dmem_req(dmem_req), .busError(busError),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  hazard_control_unit #(.TIMEOUT(16), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .IF_IDrs1(IF_IDrs1), .IF_IDrs2(IF_IDrs2),
    .IF_IDuseRs1(IF_IDuseRs1), .IF_IDuseRs2(IF_IDuseRs2),
    .ID_EXrd(ID_EXrd), .ID_EXmemRead(ID_EXmemRead),
    .EX_MEMmemRead(EX_MEMmemRead), .EX_MEMmemWrite(EX_MEMmemWrite),
    .dmem_ready(dmem_ready), .branchTaken(branchTaken),
    .PCWrite(PCWrite_s), .IF_IDWrite(IF_IDWrite_s), .ID_EXWrite(ID_EXWrite_s),
    .EX_MEMWrite(EX_MEMWrite_s), .IF_IDflush(IF_IDflush_s), .ID_EXflush(ID_EXflush_s),
    .MEM_WBflush(MEM_WBflush_s), .dmem_req(dmem_req_s), .busError(busError_s),
    .stallCount(stallCount_s), .flushCount(flushCount_s)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_IDrs1       = 5'd0;
    IF_IDrs2       = 5'd0;
    IF_IDuseRs1    = 1'b0;
    IF_IDuseRs2    = 1'b0;
    ID_EXrd        = 5'd0;
    ID_EXmemRead   = 1'b0;
    EX_MEMmemRead  = 1'b0;
    EX_MEMmemWrite = 1'b0;
    dmem_ready     = 1'b0;
    branchTaken    = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    EX_MEMmemRead = 1'b1;
    branchTaken   = 1'b1;
    #1;
    total++;
    if (ctl !== 8'b0000_1110) begin
      bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'b0000_1110);
    end
    tick();
    tick();
    total++;
    if (stallCount !== 32'd0 || flushCount !== 32'd0 || busError !== 1'b0) begin
      bad++; $display("FAIL reset_regs got stall=%0d flush=%0d berr=%b exp 0 0 0",
                      stallCount, flushCount, busError);
    end
    reset = 1'b0;
    idle();
    #1;
    total++;
    if (ctl !== 8'b1111_0000) begin
      bad++; $display("FAIL idle_ctl got=%b exp=%b", ctl, 8'b1111_0000);
    end
    tick();
  endtask

  task automatic test_load_use();
    ID_EXmemRead = 1'b1;
    ID_EXrd      = 5'd5;
    IF_IDrs1     = 5'd5;
    IF_IDuseRs1  = 1'b1;
    #1;
    total++;
    if (ctl !== 8'b0011_0100) begin
      bad++; $display("FAIL load_use_ctl got=%b exp=%b", ctl, 8'b0011_0100);
    end
    tick();
    total++;
    if (stallCount !== 32'd1) begin
      bad++; $display("FAIL load_use_stallcnt got=%0d exp=1", stallCount);
    end
    // Load has moved on to MEM: the dependency is resolved by bypass
    ID_EXmemRead = 1'b0;
    #1;
    total++;
    if (ctl !== 8'b1111_0000) begin
      bad++; $display("FAIL load_use_release got=%b exp=%b", ctl, 8'b1111_0000);
    end
    tick();
    idle();
  endtask

  task automatic test_no_stall();
    // Load into x0 with matching source
    ID_EXmemRead = 1'b1;
    ID_EXrd      = 5'd0;
    IF_IDrs1     = 5'd0;
    IF_IDuseRs1  = 1'b1;
    #1;
    total++;
    if (ctl !== 8'b1111_0000) begin
      bad++; $display("FAIL x0_no_stall got=%b exp=%b", ctl, 8'b1111_0000);
    end
    tick();
    // rs2 matches but the instruction does not read it
    ID_EXrd     = 5'd5;
    IF_IDrs1    = 5'd7;
    IF_IDrs2    = 5'd5;
    IF_IDuseRs1 = 1'b1;
    IF_IDuseRs2 = 1'b0;
    #1;
    total++;
    if (ctl !== 8'b1111_0000) begin
      bad++; $display("FAIL unused_rs2 got=%b exp=%b", ctl, 8'b1111_0000);
    end
    // Same operands with rs2 read: stall
    IF_IDuseRs2 = 1'b1;
    #1;
    total++;
    if (ctl !== 8'b0011_0100) begin
      bad++; $display("FAIL used_rs2 got=%b exp=%b", ctl, 8'b0011_0100);
    end
    tick();
    total++;
    if (stallCount !== 32'd2) begin
      bad++; $display("FAIL no_stall_cnt got=%0d exp=2", stallCount);
    end
    idle();
  endtask

  task automatic test_branch_load_use();
    ID_EXmemRead = 1'b1;
    ID_EXrd      = 5'd9;
    IF_IDrs1     = 5'd9;
    IF_IDuseRs1  = 1'b1;
    branchTaken  = 1'b1;
    #1;
    total++;
    if (ctl !== 8'b1111_1100) begin
      bad++; $display("FAIL branch_lu_ctl got=%b exp=%b", ctl, 8'b1111_1100);
    end
    tick();
    total++;
    if (flushCount !== 32'd1 || stallCount !== 32'd2) begin
      bad++; $display("FAIL branch_lu_cnt got flush=%0d stall=%0d exp 1 2",
                      flushCount, stallCount);
    end
    idle();
  endtask

  task automatic test_dmem_wait();
    EX_MEMmemRead = 1'b1;
    dmem_ready    = 1'b0;
    branchTaken   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ctl !== 8'b0000_0011) begin
        bad++; $display("FAIL wait_freeze[%0d] got=%b exp=%b", i, ctl, 8'b0000_0011);
      end
      tick();
    end
    total++;
    if (stallCount !== 32'd5 || flushCount !== 32'd1) begin
      bad++; $display("FAIL wait_cnt got stall=%0d flush=%0d exp 5 1",
                      stallCount, flushCount);
    end
    dmem_ready = 1'b1;
    #1;
    total++;
    if (ctl !== 8'b1111_1101) begin
      bad++; $display("FAIL wait_ready got=%b exp=%b", ctl, 8'b1111_1101);
    end
    tick();
    total++;
    if (flushCount !== 32'd2 || stallCount !== 32'd5) begin
      bad++; $display("FAIL wait_done_cnt got flush=%0d stall=%0d exp 2 5",
                      flushCount, stallCount);
    end
    idle();
  endtask

  task automatic test_timeout();
    EX_MEMmemWrite = 1'b1;
    dmem_ready     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++;
      if (ctl !== 8'b0000_0011 || busError !== 1'b0) begin
        bad++; $display("FAIL timeout_freeze[%0d] got=%b berr=%b exp=%b berr=0",
                        i, ctl, busError, 8'b0000_0011);
      end
      tick();
    end
    #1;
    total++;
    if (busError !== 1'b1 || ctl !== 8'b1111_0000) begin
      bad++; $display("FAIL timeout_err got berr=%b ctl=%b exp berr=1 ctl=%b",
                      busError, ctl, 8'b1111_0000);
    end
    total++;
    if (stallCount !== 32'd21 || stallCount_s !== 4'd15) begin
      bad++; $display("FAIL timeout_cnt got stall=%0d sat=%0d exp 21 15",
                      stallCount, stallCount_s);
    end
    tick();
    total++;
    if (busError !== 1'b1 || stallCount !== 32'd21) begin
      bad++; $display("FAIL busError_sticky got berr=%b stall=%0d exp 1 21",
                      busError, stallCount);
    end
    idle();
  endtask

  task automatic test_reset_mid_wait();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    EX_MEMmemRead = 1'b1;
    dmem_ready    = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (stallCount !== 32'd0 || stallCount_s !== 4'd0 || busError !== 1'b0) begin
      bad++; $display("FAIL midwait_reset got stall=%0d sat=%0d berr=%b exp 0 0 0",
                      stallCount, stallCount_s, busError);
    end
    // Full timeout window must restart from zero
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (busError !== 1'b0) begin
      bad++; $display("FAIL midwait_early_err got=%b exp=0", busError);
    end
    tick();
    total++;
    if (busError !== 1'b1 || stallCount !== 32'd16 || stallCount_s !== 4'd15) begin
      bad++; $display("FAIL midwait_timeout got berr=%b stall=%0d sat=%0d exp 1 16 15",
                      busError, stallCount, stallCount_s);
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_load_use();
    test_dmem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
